adder_share_arbiter: RTL
========================

Name: adder_share_arbiter

Overview:
- Shares one signed ripple-carry adder (WIDTH-bit operands, carry-in, WIDTH+1-bit sum, overflow flag) among NREQ requesters.
- Requesters present operand pairs under valid/ready; a round-robin arbiter grants one request at a time.
- The granted operands are captured, added, and the registered result is returned with the requester ID under valid/ready.
- Keeps a saturating count of overflowed operations for status readout.

Parameters:
- WIDTH, 4, operand width in bits (signed two's complement).
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- CNTW, 8, width of the overflow event counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i set: requester i has an operation pending.
- req_ready  output  NREQ  one-hot grant/accept strobe, at most one bit high.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing as req_a.
- req_cin  input  NREQ  carry-in per requester.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_sum  output  WIDTH+1  sign-extended sum.
- rsp_of  output  1  signed overflow of the WIDTH-bit result.
- of_count  output  CNTW  saturating count of accepted results with rsp_of=1.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_sum=0; rsp_of=0; of_count=0; busy=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - Reset dominates every other event. It aborts any in-flight operation. No response is issued for an aborted operation.
- States are IDLE, CALC and RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit at or after the pointer, searching upward with wrap-around.
  - req_ready for that bit is combinationally high in this cycle; the transfer completes on that edge.
  - On that edge: capture the requester's a, b and cin plus its ID into operand registers. Move the pointer to (granted ID + 1) mod NREQ, then go to CALC.
  - If no req_valid is set, req_ready stays 0 and the state stays IDLE.
- CALC:
  - Compute sum = sext(a) + sext(b) + cin, all WIDTH+1 bits wide.
  - of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]). This equals carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Register rsp_sum, rsp_of and rsp_id; set rsp_valid=1; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1: clear rsp_valid. If rsp_of=1, increment of_count unless it equals all ones (saturate). Go to IDLE.
  - req_ready=0.
- Latency:
  - Grant edge to rsp_valid high: 1 cycle.
  - Minimum issue interval: 3 cycles (IDLE, CALC, RESP with rsp_ready=1).
  - No back-to-back grants. A new grant is possible only in the IDLE cycle after the response is accepted.
- Fairness:
  - A requester that was just granted has lowest priority next time.
  - With all requests held continuously, the grant order is 0,1,...,NREQ-1,0,...
- req_valid may drop without being granted; no grant is issued to a deasserted requester.
- rsp_sum and rsp_of are don't-care when rsp_valid=0, but hold their last values.
- Operand values change after grant do not affect the captured result.

Test Plan:
- Reset then a single request: requester 2 with a=0011, b=0010, cin=0. req_ready[2] pulses for one cycle. rsp_valid=1 one cycle later with rsp_id=2, rsp_sum=00101, rsp_of=0.
- Positive overflow: a=0111, b=0001, cin=0 gives rsp_sum=01000, rsp_of=1. After the response is accepted, of_count increments 0→1.
- Negative overflow with carry-in: a=1000, b=1111, cin=0 gives rsp_sum=10111, rsp_of=1. Also a=1111, b=1111, cin=1 gives rsp_sum=11111, rsp_of=0.
- Round-robin: all four req_valid held high, rsp_ready=1. Grant order is 0,1,2,3,0, with grants spaced 3 cycles apart. Drop req_valid[1] before its turn; the order becomes 0,2,3,0.
- Backpressure and reset: hold rsp_ready=0 for 5 cycles; rsp_* stay stable, busy=1, and req_ready stays 0 despite pending requests. Assert rst in RESP; the next cycle shows rsp_valid=0, of_count=0, and first priority back at requester 0.
- Counter saturation: with CNTW=2, accept 5 overflowing results; of_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin shared signed adder: NREQ requesters time-share one WIDTH-bit
// adder; results return tagged with the owner ID, overflows are counted.
module adder_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH:0]        rsp_sum,
    output logic                  rsp_of,
    output logic [CNTW-1:0]       of_count,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

    state_t           state, state_nx;
    logic [IDW-1:0]   ptr, ptr_nx, gnt_id, op_id;
    logic [IDW:0]     idx;
    logic             gnt_any;
    logic [WIDTH-1:0] lane_a [NREQ];
    logic [WIDTH-1:0] lane_b [NREQ];
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_cin;
    logic [WIDTH:0]   sum;
    logic             of;

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign lane_a[g] = req_a[g*WIDTH +: WIDTH];
        assign lane_b[g] = req_b[g*WIDTH +: WIDTH];
    end

    // First pending requester at or after ptr, wrapping past NREQ-1.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (!gnt_any && req_valid[idx[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[IDW-1:0];
            end
        end
    end

    assign ptr_nx = (gnt_id == LAST) ? '0 : gnt_id + IDW'(1);

    assign sum = {op_a[WIDTH-1], op_a} + {op_b[WIDTH-1], op_b} + {{WIDTH{1'b0}}, op_cin};
    assign of  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        case (state)
            IDLE: if (gnt_any) begin
                req_ready[gnt_id] = 1'b1;
                state_nx          = CALC;
            end
            CALC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_of    <= 1'b0;
            of_count  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (gnt_any) begin
                    op_a   <= lane_a[gnt_id];
                    op_b   <= lane_b[gnt_id];
                    op_cin <= req_cin[gnt_id];
                    op_id  <= gnt_id;
                    ptr    <= ptr_nx;
                end
                CALC: begin
                    rsp_sum   <= sum;
                    rsp_of    <= of;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    if (rsp_of && of_count != '1) of_count <= of_count + CNTW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
